mast_shift_engine: RTL and testbench
====================================

Name: mast_shift_engine

Overview:
- Parametrised, bidirectional serial data engine for the I2C master datapath; successor to the master's fixed 8-bit transmit-only shift register.
- Transmit mode: loads a DATA_WIDTH word and shifts it onto the master SDA drive path, MSB- or LSB-first.
- Receive mode: assembles DATA_WIDTH bits sampled from SDA into a parallel word.
- Owns its own bit counter and a busy/done handshake, so the master FSM only issues load and per-bit shift strobes.

Parameters:
- DATA_WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = shift MSB first (I2C standard); 0 = LSB first.
- CNT_W, $clog2(DATA_WIDTH+1), bit counter width; derived, not overridden.

Ports:
- master_scl_sixt  input  1  block clock; all state updates on its falling edge.
- master_rst  input  1  asynchronous, active-high reset.
- master_load_data  input  1  start a new word; sampled on the clock edge.
- master_dir  input  1  mode, captured at load: 0 = transmit, 1 = receive.
- master_data  input  DATA_WIDTH  transmit word, captured at load.
- master_shift_data  input  1  one-bit shift strobe.
- master_serial_in_data  input  1  sampled SDA value in receive mode.
- master_serial_out_data  output  1  SDA drive value; 1 = release.
- master_rx_data  output  DATA_WIDTH  last completed received word.
- master_busy  output  1  high while a word is in progress.
- master_done  output  1  one-cycle pulse when the word completes.
- master_bit_count  output  CNT_W  number of bits shifted so far in the current word.

Behaviour:
- Reset (asynchronous, active-high, effective immediately):
  - state = IDLE; shift register = 0; master_bit_count = 0; dir register = 0.
  - master_rx_data = 0; master_busy = 0; master_done = 0; master_serial_out_data = 1.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy = 0; serial_out = 1.
  - On load: capture dir. Shift register = master_data if transmitting, 0 if receiving. Count = 0. Go to SHIFT.
  - Shift strobes are ignored.
- SHIFT:
  - busy = 1.
  - Transmit, serial_out = current head bit: bit DATA_WIDTH-1 if MSB_FIRST, else bit 0.
  - Transmit, on a strobe: shift toward the head and fill the vacated end with 0.
  - Receive: serial_out = 1 at all times, so the master releases SDA.
  - Receive, on a strobe: shift toward the head and insert serial_in at the tail (bit 0 if MSB_FIRST, else bit DATA_WIDTH-1).
  - Every strobe increments count.
  - On the strobe that brings count to DATA_WIDTH: go to DONE. If receiving, master_rx_data takes the completed word, including the bit sampled on this edge, on the same edge.
- DONE:
  - Lasts exactly one cycle. done = 1, busy = 0, serial_out = 1 (released for the ACK bit), count holds at DATA_WIDTH.
  - Next edge: go to IDLE, unless load is high; then start a new word exactly as from IDLE (back-to-back).
- Latency:
  - First transmit bit is valid on serial_out in the cycle after the load edge.
  - done asserts in the cycle after the DATA_WIDTH-th strobe edge.
- Simultaneous load and shift:
  - Load wins and the strobe is discarded, in any state.
  - A load during SHIFT aborts the current word and restarts with count = 0.
  - An aborted receive word never updates master_rx_data and produces no done pulse.
- Between strobes, when shift and load are both low: all state holds.
- master_rx_data holds its value until the next completed receive word; transmit words never alter it.
- Reset mid-word: immediate return to IDLE with all reset values; no done pulse.

Test Plan:
- Default parameters, transmit 8'hA5, eight strobes on consecutive cycles:
  - serial_out sequence 1,0,1,0,0,1,0,1.
  - done pulses once, in the cycle after the 8th strobe.
  - serial_out = 1 during DONE.
  - bit_count steps 0..8.
- Default parameters, receive with serial_in sequence 1,1,0,0,1,0,1,0:
  - rx_data = 8'hCA with done.
  - serial_out stays 1 throughout.
  - busy is high for the full word.
- MSB_FIRST=0, DATA_WIDTH=16, transmit 16'h8001:
  - serial_out sequence 1, then fourteen 0s, then 1.
  - done after 16 strobes.
- Load asserted together with the 4th strobe of a receive word:
  - strobe discarded; count returns to 0; no done pulse; rx_data unchanged.
  - Next 8 strobes complete the new word normally.
- Reset asserted mid-edge-cycle after 3 transmit strobes:
  - outputs immediately at reset values (serial_out = 1, busy = 0, bit_count = 0).
  - Strobes issued without a load after reset release have no effect.
- Load held high in DONE, transmit 8'hFF followed by 8'h00:
  - second word starts without passing through IDLE.
  - busy is low only during the DONE cycle.
  - serial_out = 0 in the cycle after the DONE cycle.

Source files
------------

// File: rtl/mast_shift_engine_if.sv
// Bus between the I2C master FSM and the serial shift engine.
// The master modport issues load and shift strobes; the slave modport is the engine.
interface mast_shift_engine_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    logic                  master_load_data;
    logic                  master_dir;
    logic [DATA_WIDTH-1:0] master_data;
    logic                  master_shift_data;
    logic                  master_serial_in_data;
    logic                  master_serial_out_data;
    logic [DATA_WIDTH-1:0] master_rx_data;
    logic                  master_busy;
    logic                  master_done;
    logic [CNT_W-1:0]      master_bit_count;

    modport master (
        output master_load_data,
        output master_dir,
        output master_data,
        output master_shift_data,
        output master_serial_in_data,
        input  master_serial_out_data,
        input  master_rx_data,
        input  master_busy,
        input  master_done,
        input  master_bit_count
    );

    modport slave (
        input  master_load_data,
        input  master_dir,
        input  master_data,
        input  master_shift_data,
        input  master_serial_in_data,
        output master_serial_out_data,
        output master_rx_data,
        output master_busy,
        output master_done,
        output master_bit_count
    );
endinterface

// File: rtl/mast_shift_engine.sv
// Bidirectional serial shift engine for the I2C master datapath.
// Transmit: shifts a loaded word onto the SDA drive path, MSB- or LSB-first.
// Receive: assembles DATA_WIDTH sampled SDA bits into a parallel word.
// All state changes on the falling edge of master_scl_sixt.
module mast_shift_engine #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input logic             master_scl_sixt,
    input logic             master_rst,
    mast_shift_engine_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DATA_WIDTH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    if (DATA_WIDTH < 2 || DATA_WIDTH > 32) begin : g_bad_width
        $error("mast_shift_engine: DATA_WIDTH must be in 2..32");
    end

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  dir_q, dir_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;

    logic                  tail_bit;
    logic                  head_bit;
    logic [DATA_WIDTH-1:0] shifted;

    // Shift toward the head; transmit fills with 0, receive inserts the sampled SDA bit.
    always_comb begin
        tail_bit = dir_q & bus.master_serial_in_data;
        if (MSB_FIRST) begin
            shifted  = {sreg_q[DATA_WIDTH-2:0], tail_bit};
            head_bit = sreg_q[DATA_WIDTH-1];
        end else begin
            shifted  = {tail_bit, sreg_q[DATA_WIDTH-1:1]};
            head_bit = sreg_q[0];
        end
    end

    // Next-state logic; a load outranks a strobe in every state.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rx_d    = rx_q;

        if (bus.master_load_data) begin
            // Start (or restart) a word; an aborted word leaves rx_q untouched.
            dir_d   = bus.master_dir;
            sreg_d  = bus.master_dir ? '0 : bus.master_data;
            cnt_d   = '0;
            state_d = StShift;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StShift: begin
                    if (bus.master_shift_data) begin
                        sreg_d = shifted;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == LastCnt) begin
                            state_d = StDone;
                            // Completed word includes the bit sampled on this edge.
                            if (dir_q) begin
                                rx_d = shifted;
                            end
                        end
                    end
                end
                StDone: begin
                    // Count deliberately holds at DATA_WIDTH through DONE and IDLE.
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(negedge master_scl_sixt or posedge master_rst) begin
        if (master_rst) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            rx_q    <= rx_d;
        end
    end

    // Outputs decode straight from state so reset values appear immediately.
    always_comb begin
        bus.master_busy            = (state_q == StShift);
        bus.master_done            = (state_q == StDone);
        bus.master_serial_out_data = (state_q == StShift && !dir_q) ? head_bit : 1'b1;
        bus.master_rx_data         = rx_q;
        bus.master_bit_count       = cnt_q;
    end

`ifndef SYNTHESIS
    a_done_not_busy: assert property (@(negedge master_scl_sixt) disable iff (master_rst)
        !(bus.master_done && bus.master_busy));

    a_done_single: assert property (@(negedge master_scl_sixt) disable iff (master_rst)
        bus.master_done |=> !bus.master_done);

    a_count_bound: assert property (@(negedge master_scl_sixt) disable iff (master_rst)
        cnt_q <= FullCnt);

    a_release_idle: assert property (@(negedge master_scl_sixt) disable iff (master_rst)
        !bus.master_busy |-> bus.master_serial_out_data);
`endif

endmodule

// File: tb/tb_mast_shift_engine.sv
// Self-checking bench: two engines (8-bit MSB-first and 16-bit LSB-first) share one
// random/directed stimulus stream and are compared each cycle to a word-level model.
module tb_mast_shift_engine;
    logic        clk;
    logic        rst;
    logic        load;
    logic        dir;
    logic [31:0] data;
    logic        shift;
    logic        sin;

    int n_tests = 0;
    int n_fail  = 0;

    mast_shift_engine_if #(.DATA_WIDTH(8))  bus0 ();
    mast_shift_engine_if #(.DATA_WIDTH(16)) bus1 ();

    assign bus0.master_load_data      = load;
    assign bus0.master_dir            = dir;
    assign bus0.master_data           = data[7:0];
    assign bus0.master_shift_data     = shift;
    assign bus0.master_serial_in_data = sin;
    assign bus1.master_load_data      = load;
    assign bus1.master_dir            = dir;
    assign bus1.master_data           = data[15:0];
    assign bus1.master_shift_data     = shift;
    assign bus1.master_serial_in_data = sin;

    mast_shift_engine #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut0 (
        .master_scl_sixt (clk),
        .master_rst      (rst),
        .bus             (bus0)
    );

    mast_shift_engine #(.DATA_WIDTH(16), .MSB_FIRST(1'b0)) dut1 (
        .master_scl_sixt (clk),
        .master_rst      (rst),
        .bus             (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-level reference model, one slot per engine.
    int unsigned W[2]   = '{8, 16};
    bit          MSB[2] = '{1'b1, 1'b0};
    bit          m_active[2];
    bit          m_done[2];
    bit          m_dir[2];
    logic [31:0] m_word[2];
    logic [31:0] m_acc[2];
    logic [31:0] m_rx[2];
    int          m_cnt[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_done[i]   = 1'b0;
            m_dir[i]    = 1'b0;
            m_word[i]   = '0;
            m_acc[i]    = '0;
            m_rx[i]     = '0;
            m_cnt[i]    = 0;
        end
    endtask

    task automatic model_edge();
        logic [31:0] mask;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            mask = (32'd1 << W[i]) - 32'd1;
            if (load) begin
                m_active[i] = 1'b1;
                m_done[i]   = 1'b0;
                m_dir[i]    = dir;
                m_word[i]   = data & mask;
                m_acc[i]    = '0;
                m_cnt[i]    = 0;
            end else if (m_done[i]) begin
                m_done[i] = 1'b0;
            end else if (m_active[i] && shift) begin
                if (m_dir[i]) begin
                    if (MSB[i]) m_acc[i] = ((m_acc[i] << 1) | 32'(sin)) & mask;
                    else        m_acc[i] = m_acc[i] | (32'(sin) << m_cnt[i]);
                end
                m_cnt[i]++;
                if (m_cnt[i] == int'(W[i])) begin
                    m_active[i] = 1'b0;
                    m_done[i]   = 1'b1;
                    if (m_dir[i]) m_rx[i] = m_acc[i];
                end
            end
        end
    endtask

    function automatic logic exp_so(input int i);
        int pos;
        if (!(m_active[i] && !m_dir[i])) return 1'b1;
        pos = MSB[i] ? int'(W[i]) - 1 - m_cnt[i] : m_cnt[i];
        return m_word[i][pos];
    endfunction

    task automatic compare_all();
        check("so0",   32'(bus0.master_serial_out_data), 32'(exp_so(0)));
        check("busy0", 32'(bus0.master_busy),            32'(m_active[0]));
        check("done0", 32'(bus0.master_done),            32'(m_done[0]));
        check("cnt0",  32'(bus0.master_bit_count),       32'(m_cnt[0]));
        check("rx0",   32'(bus0.master_rx_data),         m_rx[0]);
        check("so1",   32'(bus1.master_serial_out_data), 32'(exp_so(1)));
        check("busy1", 32'(bus1.master_busy),            32'(m_active[1]));
        check("done1", 32'(bus1.master_done),            32'(m_done[1]));
        check("cnt1",  32'(bus1.master_bit_count),       32'(m_cnt[1]));
        check("rx1",   32'(bus1.master_rx_data),         m_rx[1]);
    endtask

    // One engine clock: falling edge updates, rising edge samples, then drive window.
    task automatic cycle();
        @(negedge clk);
        model_edge();
        @(posedge clk);
        compare_all();
        #1;
    endtask

    task automatic drive(input logic l, input logic d, input logic [31:0] v,
                         input logic s, input logic si);
        load  = l;
        dir   = d;
        data  = v;
        shift = s;
        sin   = si;
        cycle();
    endtask

    logic [7:0]  a5_bits;
    logic [7:0]  rx_bits;
    logic [7:0]  rx2_bits;

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        dir   = 1'b0;
        data  = '0;
        shift = 1'b0;
        sin   = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_so0", 32'(bus0.master_serial_out_data), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Transmit 8'hA5 MSB-first.
        drive(1'b1, 1'b0, 32'h0000_00A5, 1'b0, 1'b0);
        a5_bits = 8'b1010_0101;
        for (int k = 0; k < 8; k++) begin
            check("tx_a5_bit", 32'(bus0.master_serial_out_data), 32'(a5_bits[7-k]));
            check("tx_a5_cnt", 32'(bus0.master_bit_count), 32'(k));
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        check("tx_a5_done", 32'(bus0.master_done), 32'd1);
        check("tx_a5_rel",  32'(bus0.master_serial_out_data), 32'd1);
        check("tx_a5_cnt8", 32'(bus0.master_bit_count), 32'd8);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("tx_a5_done_off", 32'(bus0.master_done), 32'd0);

        // Receive 1,1,0,0,1,0,1,0 -> 8'hCA.
        rx_bits = 8'b1100_1010;
        drive(1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            check("rx_busy", 32'(bus0.master_busy), 32'd1);
            check("rx_so",   32'(bus0.master_serial_out_data), 32'd1);
            drive(1'b0, 1'b1, 32'h0, 1'b1, rx_bits[7-k]);
        end
        check("rx_ca",      32'(bus0.master_rx_data), 32'h0000_00CA);
        check("rx_ca_done", 32'(bus0.master_done), 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // 16-bit LSB-first transmit of 16'h8001 on the second engine.
        drive(1'b1, 1'b0, 32'h0000_8001, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            check("tx16_bit", 32'(bus1.master_serial_out_data),
                  (k == 0 || k == 15) ? 32'd1 : 32'd0);
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        check("tx16_done", 32'(bus1.master_done), 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Load collides with the 4th receive strobe: word restarts.
        drive(1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 32'h0, 1'b1, 1'b1);
        check("abort_cnt",  32'(bus0.master_bit_count), 32'd0);
        check("abort_rx",   32'(bus0.master_rx_data), 32'h0000_00CA);
        check("abort_done", 32'(bus0.master_done), 32'd0);
        rx2_bits = 8'b1001_0110;
        for (int k = 0; k < 8; k++) drive(1'b0, 1'b1, 32'h0, 1'b1, rx2_bits[7-k]);
        check("restart_rx",   32'(bus0.master_rx_data), 32'h0000_0096);
        check("restart_done", 32'(bus0.master_done), 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle after 3 transmit strobes.
        drive(1'b1, 1'b0, 32'h0000_00A5, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_so",   32'(bus0.master_serial_out_data), 32'd1);
        check("arst_busy", 32'(bus0.master_busy), 32'd0);
        check("arst_cnt",  32'(bus0.master_bit_count), 32'd0);
        check("arst_rx",   32'(bus0.master_rx_data), 32'd0);
        model_reset();
        compare_all();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("post_rst_cnt",  32'(bus0.master_bit_count), 32'd0);
        check("post_rst_busy", 32'(bus0.master_busy), 32'd0);

        // Back-to-back: 8'hFF then 8'h00 with load asserted during DONE.
        drive(1'b1, 1'b0, 32'h0000_00FF, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("b2b_done", 32'(bus0.master_done), 32'd1);
        check("b2b_busy_done", 32'(bus0.master_busy), 32'd0);
        drive(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        check("b2b_busy", 32'(bus0.master_busy), 32'd1);
        check("b2b_so",   32'(bus0.master_serial_out_data), 32'd0);
        check("b2b_nodone", 32'(bus0.master_done), 32'd0);

        // Random traffic with occasional mid-cycle resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                compare_all();
                rst = 1'b0;
            end
            drive(($urandom_range(0, 19) == 0), 1'($urandom), $urandom,
                  ($urandom_range(0, 2) != 0), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
